contador_updown_display: RTL and testbench
==========================================

Name: contador_updown_display

Overview:
Parametrised up/down counter with synchronous load, enable, programmable maximum value and a wrap or saturate mode. It is the successor to the fixed down-counter driving two seven-segment digits. It drives a generic number of hex seven-segment digits through a registered decode stage. It also flags wrap and limit events for downstream control logic on the FPGA board top level.

Parameters:
N, 6, counter width in bits (N >= 2)
MAX_VAL, 2**N-1, highest legal count value (1 <= MAX_VAL <= 2**N-1)
WRAP, 1, 1 = wrap at the limits; 0 = saturate at the limits
DIGITS, 2, number of hex display digits (DIGITS >= ceil(N/4))

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
en  input  1  count enable
up  input  1  direction: 1 = increment, 0 = decrement
load  input  1  synchronous load strobe
number  input  N  load value
contador  output  N  current count (registered)
wrap_pulse  output  1  one-cycle pulse after a wrap event
at_limit  output  1  high while contador == MAX_VAL (up=1) or contador == 0 (up=0)
segments  output  7*DIGITS  seven-segment drive, digit i at bits [7i+6:7i]; active-low; bit0 = a … bit6 = g

Behaviour:
- Reset (asynchronous, active-high): contador = 0, wrap_pulse = 0, segments = all ones (all segments off). Reset overrides everything. Deassertion takes effect at the next rising clk edge.
- Per-edge priority is load > en > hold.
- load=1: contador <= min(number, MAX_VAL). Values above MAX_VAL clamp to MAX_VAL. Load never asserts wrap_pulse. Load wins over en regardless of direction.
- en=1, load=0, up=1:
  - contador < MAX_VAL: contador + 1.
  - contador == MAX_VAL and WRAP=1: contador becomes 0 and wrap_pulse is set for the next cycle.
  - contador == MAX_VAL and WRAP=0: hold, no pulse.
- en=1, load=0, up=0:
  - contador > 0: contador − 1.
  - contador == 0 and WRAP=1: contador becomes MAX_VAL and wrap_pulse is set.
  - contador == 0 and WRAP=0: hold, no pulse.
- en=0, load=0: hold, wrap_pulse = 0.
- Out-of-range count: if contador > MAX_VAL at any enabled edge (unreachable in normal operation), the next value is 0.
- wrap_pulse: registered, exactly one cycle wide per wrap event. Back-to-back wraps give consecutive pulses (e.g. MAX_VAL=1 with wrap active every cycle).
- at_limit: combinational from contador and up. It changes in the same cycle as a change of up.
- Display stage: digit i = contador[4i+3:4i], zero-extended above N−1. Digits wholly above N are 0.
- Digit decode is full hex, active-low (segment order g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- segments is registered, so it lags contador by exactly one clk cycle.
- Arithmetic is N-bit unsigned. No internal state beyond contador, wrap_pulse and the segments register.

Test Plan:
- Reset mid-count: count to 5, assert reset asynchronously between edges -> contador=0 and segments=all ones immediately. Counting resumes from 0 one edge after release.
- Up wrap (N=6, MAX_VAL=63, WRAP=1): load 62, en=1 up=1 for 3 edges -> 63, 0, 1. wrap_pulse is high only in the cycle after the 63→0 edge. at_limit is high while contador=63.
- Down saturate (WRAP=0, MAX_VAL=40): load 2, en=1 up=0 for 4 edges -> 1, 0, 0, 0. wrap_pulse is never set; at_limit=1 from the first 0 onward.
- Load clamp and priority (MAX_VAL=40): number=50 with load=1, en=1 -> contador=40. Next edge, load=0 up=1 with WRAP=1 -> contador=0 and wrap_pulse=1.
- Display latency: load 0x13 -> one cycle later segments digit1=1111001 ("1") and digit0=0110000 ("3"). Load 0x2F -> digit1=0100100, digit0=0001110.
- Down wrap and hold: contador=0, WRAP=1, up=0 en=1 -> contador=MAX_VAL with pulse. en=0 for 3 edges -> value holds and wrap_pulse=0.

Source files
------------

// File: rtl/contador_updown_display_if.sv
// Bus for the up/down counter: control strobes and load value in, count, event flags and display drive out.
interface contador_updown_display_if #(
  parameter int N      = 6,
  parameter int DIGITS = 2
);
  logic                  en;
  logic                  up;
  logic                  load;
  logic [N-1:0]          number;
  logic [N-1:0]          contador;
  logic                  wrap_pulse;
  logic                  at_limit;
  logic [7*DIGITS-1:0]   segments;

  modport master (
    output en, up, load, number,
    input  contador, wrap_pulse, at_limit, segments
  );

  modport slave (
    input  en, up, load, number,
    output contador, wrap_pulse, at_limit, segments
  );
endinterface

// File: rtl/contador_updown_display.sv
// Up/down counter with clamped load, wrap/saturate limits, wrap pulse and a registered
// hex seven-segment decode (active-low, g..a) that lags the count by one cycle.
module contador_updown_display #(
  parameter int N       = 6,
  parameter int MAX_VAL = (1 << N) - 1,
  parameter bit WRAP    = 1'b1,
  parameter int DIGITS  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  contador_updown_display_if.slave bus
);
  localparam int           EXT_W = 4 * DIGITS;
  localparam logic [N-1:0] MAX_C = N'(MAX_VAL);
  localparam logic [N-1:0] ONE_C = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0]        contador_r;
  logic                wrap_r;
  logic [7*DIGITS-1:0] segments_r;
  logic [N-1:0]        next_s;
  logic                wrap_s;
  logic [EXT_W-1:0]    ext_s;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      4'hF:    s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Next-count and wrap-event selection; priority load > en > hold
  always_comb begin
    next_s = contador_r;
    wrap_s = 1'b0;
    if (bus.load) begin
      next_s = (bus.number > MAX_C) ? MAX_C : bus.number;
    end else if (bus.en) begin
      if (contador_r > MAX_C) begin
        next_s = '0;
      end else if (bus.up) begin
        if (contador_r < MAX_C) begin
          next_s = contador_r + ONE_C;
        end else if (WRAP) begin
          next_s = '0;
          wrap_s = 1'b1;
        end else begin
          next_s = contador_r;
        end
      end else begin
        if (contador_r != '0) begin
          next_s = contador_r - ONE_C;
        end else if (WRAP) begin
          next_s = MAX_C;
          wrap_s = 1'b1;
        end else begin
          next_s = contador_r;
        end
      end
    end else begin
      next_s = contador_r;
    end
  end

  // Count and wrap-pulse registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      contador_r <= '0;
      wrap_r     <= 1'b0;
    end else begin
      contador_r <= next_s;
      wrap_r     <= wrap_s;
    end
  end

  // Digits above the counter width read as zero
  assign ext_s = EXT_W'(contador_r);

  // Display register decodes the current count, hence one cycle behind it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      segments_r <= '1;
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        segments_r[7*i +: 7] <= hex7(ext_s[4*i +: 4]);
      end
    end
  end

  assign bus.contador   = contador_r;
  assign bus.wrap_pulse = wrap_r;
  assign bus.segments   = segments_r;
  assign bus.at_limit   = bus.up ? (contador_r == MAX_C) : (contador_r == '0);
endmodule

// File: tb/tb_contador_updown_display.sv
// Directed bench: three counter configurations (63/wrap, 40/saturate, 40/wrap) with hand-computed expectations.
module tb_contador_updown_display;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  contador_updown_display_if #(.N(6), .DIGITS(2)) bus_a ();
  contador_updown_display_if #(.N(6), .DIGITS(2)) bus_b ();
  contador_updown_display_if #(.N(6), .DIGITS(2)) bus_c ();

  contador_updown_display #(.N(6), .MAX_VAL(63), .WRAP(1'b1), .DIGITS(2)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a));
  contador_updown_display #(.N(6), .MAX_VAL(40), .WRAP(1'b0), .DIGITS(2)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b));
  contador_updown_display #(.N(6), .MAX_VAL(40), .WRAP(1'b1), .DIGITS(2)) dut_c (
    .clk(clk), .reset(reset), .bus(bus_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset = 1'b1;
    bus_a.en = 1'b0; bus_a.up = 1'b0; bus_a.load = 1'b0; bus_a.number = 6'd0;
    bus_b.en = 1'b0; bus_b.up = 1'b0; bus_b.load = 1'b0; bus_b.number = 6'd0;
    bus_c.en = 1'b0; bus_c.up = 1'b0; bus_c.load = 1'b0; bus_c.number = 6'd0;
    #12;
    check("rst_cnt", 32'(bus_a.contador), 32'd0);
    check("rst_seg", 32'(bus_a.segments), 32'h3FFF);
    check("rst_wrap", 32'(bus_a.wrap_pulse), 32'd0);
    check("rst_lim_dn", 32'(bus_a.at_limit), 32'd1);
    reset = 1'b0;

    // Reset mid-count
    bus_a.en = 1'b1; bus_a.up = 1'b1;
    repeat (5) step();
    check("cnt5", 32'(bus_a.contador), 32'd5);
    #2; reset = 1'b1;
    #1;
    check("async_rst_cnt", 32'(bus_a.contador), 32'd0);
    check("async_rst_seg", 32'(bus_a.segments), 32'h3FFF);
    #3; reset = 1'b0;
    step();
    check("resume_cnt", 32'(bus_a.contador), 32'd1);
    check("resume_seg", 32'(bus_a.segments), 32'({7'b1000000, 7'b1000000}));

    // Up wrap on A
    bus_a.en = 1'b0; bus_a.load = 1'b1; bus_a.number = 6'd62;
    step();
    check("load62", 32'(bus_a.contador), 32'd62);
    bus_a.load = 1'b0; bus_a.en = 1'b1; bus_a.up = 1'b1;
    step();
    check("up63", 32'(bus_a.contador), 32'd63);
    check("up63_lim", 32'(bus_a.at_limit), 32'd1);
    check("up63_wrap", 32'(bus_a.wrap_pulse), 32'd0);
    step();
    check("wrap0", 32'(bus_a.contador), 32'd0);
    check("wrap0_pulse", 32'(bus_a.wrap_pulse), 32'd1);
    check("wrap0_lim", 32'(bus_a.at_limit), 32'd0);
    step();
    check("wrap1", 32'(bus_a.contador), 32'd1);
    check("wrap1_pulse", 32'(bus_a.wrap_pulse), 32'd0);
    bus_a.en = 1'b0;

    // Down saturate on B
    bus_b.load = 1'b1; bus_b.number = 6'd2;
    step();
    check("b_load2", 32'(bus_b.contador), 32'd2);
    bus_b.load = 1'b0; bus_b.en = 1'b1; bus_b.up = 1'b0;
    step();
    check("b_dn1", 32'(bus_b.contador), 32'd1);
    check("b_dn1_lim", 32'(bus_b.at_limit), 32'd0);
    step();
    check("b_dn0", 32'(bus_b.contador), 32'd0);
    check("b_dn0_lim", 32'(bus_b.at_limit), 32'd1);
    step();
    check("b_sat0", 32'(bus_b.contador), 32'd0);
    check("b_sat0_wrap", 32'(bus_b.wrap_pulse), 32'd0);
    step();
    check("b_sat0b", 32'(bus_b.contador), 32'd0);
    check("b_sat0b_wrap", 32'(bus_b.wrap_pulse), 32'd0);
    bus_b.load = 1'b1; bus_b.number = 6'd40; bus_b.up = 1'b1;
    step();
    bus_b.load = 1'b0;
    step();
    check("b_sat40", 32'(bus_b.contador), 32'd40);
    check("b_sat40_lim", 32'(bus_b.at_limit), 32'd1);
    check("b_sat40_wrap", 32'(bus_b.wrap_pulse), 32'd0);
    bus_b.en = 1'b0;

    // Load clamp and priority on C
    bus_c.load = 1'b1; bus_c.en = 1'b1; bus_c.up = 1'b1; bus_c.number = 6'd50;
    step();
    check("c_clamp", 32'(bus_c.contador), 32'd40);
    check("c_clamp_wrap", 32'(bus_c.wrap_pulse), 32'd0);
    bus_c.load = 1'b0;
    step();
    check("c_upwrap", 32'(bus_c.contador), 32'd0);
    check("c_upwrap_pulse", 32'(bus_c.wrap_pulse), 32'd1);

    // Down wrap then hold on C
    bus_c.up = 1'b0;
    step();
    check("c_dnwrap", 32'(bus_c.contador), 32'd40);
    check("c_dnwrap_pulse", 32'(bus_c.wrap_pulse), 32'd1);
    check("c_dnwrap_lim", 32'(bus_c.at_limit), 32'd0);
    bus_c.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("c_hold", 32'(bus_c.contador), 32'd40);
      check("c_hold_wrap", 32'(bus_c.wrap_pulse), 32'd0);
    end
    bus_c.up = 1'b1;
    #1;
    check("c_lim_up", 32'(bus_c.at_limit), 32'd1);

    // Display latency on A
    bus_a.load = 1'b1; bus_a.number = 6'h13;
    step();
    check("disp_cnt13", 32'(bus_a.contador), 32'h13);
    bus_a.number = 6'h2F;
    step();
    check("disp_seg13", 32'(bus_a.segments), 32'({7'b1111001, 7'b0110000}));
    check("disp_cnt2f", 32'(bus_a.contador), 32'h2F);
    bus_a.load = 1'b0;
    step();
    check("disp_seg2f", 32'(bus_a.segments), 32'({7'b0100100, 7'b0001110}));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
